// File: rtl/branch_resolver.sv
// Branch outcome resolver with 2-bit BHT, registered redirect and flush window.
// Optional statistics counters: define BR_RESOLVER_STATS_EN.
module branch_resolver #(
  parameter int IDX_W        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_fetchPc,
  output logic        o_predTaken,
  input  logic        i_valid,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_target,
  input  logic [2:0]  i_funct3,
  input  logic        i_predTaken,
  output logic        o_brUnsign,
  input  logic        i_brLess,
  input  logic        i_brEqual,
  output logic        o_taken,
  output logic        o_mispredict,
  output logic [31:0] o_redirectPc,
  output logic        o_illegal,
  output logic [31:0] o_brCount,
  output logic [31:0] o_mispCount
);

  localparam int N  = 1 << IDX_W;
  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_bht [N];
  logic            r_misp;
  logic            r_ill;
  logic [31:0]     r_rpc;

  logic [IDX_W-1:0] w_fidx;
  logic [IDX_W-1:0] w_uidx;
  logic             w_dec;
  logic             w_legal;
  logic             w_accept;
  logic             w_upd;
  logic             w_misp;
  logic             w_unused;

  assign w_fidx   = i_fetchPc[IDX_W+1:2];
  assign w_uidx   = i_pc[IDX_W+1:2];
  assign w_unused = ^{i_fetchPc[31:IDX_W+2], i_fetchPc[1:0]};

  always_comb begin
    w_dec   = 1'b0;
    w_legal = 1'b1;
    case (i_funct3)
      3'b000:  w_dec = i_brEqual;
      3'b001:  w_dec = !i_brEqual;
      3'b100:  w_dec = i_brLess;
      3'b101:  w_dec = !i_brLess;
      3'b110:  w_dec = i_brLess;
      3'b111:  w_dec = !i_brLess;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_accept = i_valid && (r_state == IDLE) && !i_reset;
  assign w_upd    = w_accept && w_legal;
  assign w_misp   = w_upd && (w_dec != i_predTaken);

  assign o_brUnsign   = i_funct3[1];
  assign o_taken      = w_accept && w_dec;
  assign o_predTaken  = r_bht[w_fidx][1];
  assign o_mispredict = r_misp;
  assign o_illegal    = r_ill;
  assign o_redirectPc = r_rpc;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_misp  <= 1'b0;
      r_ill   <= 1'b0;
      r_rpc   <= '0;
    end else begin
      r_misp <= w_misp;
      r_ill  <= w_accept && !w_legal;
      if (w_misp)
        r_rpc <= w_dec ? i_target : i_pc + 32'd4;
      unique case (r_state)
        IDLE: begin
          if (w_misp) begin
            r_state <= FLUSH;
            r_cnt   <= CW'(FLUSH_CYCLES - 1);
          end
        end
        FLUSH: begin
          if (r_cnt == '0)
            r_state <= IDLE;
          else
            r_cnt <= r_cnt - CW'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Saturating counters; reset to weakly not-taken.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < N; k++)
        r_bht[k] <= 2'b01;
    end else if (w_upd) begin
      if (w_dec && r_bht[w_uidx] != 2'b11)
        r_bht[w_uidx] <= r_bht[w_uidx] + 2'b01;
      else if (!w_dec && r_bht[w_uidx] != 2'b00)
        r_bht[w_uidx] <= r_bht[w_uidx] - 2'b01;
    end
  end

`ifdef BR_RESOLVER_STATS_EN
  logic [31:0] r_brCount;
  logic [31:0] r_mispCount;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_brCount   <= '0;
      r_mispCount <= '0;
    end else begin
      if (w_upd)
        r_brCount <= r_brCount + 32'd1;
      if (w_misp)
        r_mispCount <= r_mispCount + 32'd1;
    end
  end

  assign o_brCount   = r_brCount;
  assign o_mispCount = r_mispCount;
`else
  assign o_brCount   = 32'h0;
  assign o_mispCount = 32'h0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: vector table plus
// scoreboarded registered outputs and flush/BHT/reset sequences.
module tb_branch_resolver;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_fetchPc;
  logic        o_predTaken;
  logic        i_valid;
  logic [31:0] i_pc;
  logic [31:0] i_target;
  logic [2:0]  i_funct3;
  logic        i_predTaken;
  logic        o_brUnsign;
  logic        i_brLess;
  logic        i_brEqual;
  logic        o_taken;
  logic        o_mispredict;
  logic [31:0] o_redirectPc;
  logic        o_illegal;
  logic [31:0] o_brCount;
  logic [31:0] o_mispCount;

  branch_resolver dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_fetchPc    (i_fetchPc),
    .o_predTaken  (o_predTaken),
    .i_valid      (i_valid),
    .i_pc         (i_pc),
    .i_target     (i_target),
    .i_funct3     (i_funct3),
    .i_predTaken  (i_predTaken),
    .o_brUnsign   (o_brUnsign),
    .i_brLess     (i_brLess),
    .i_brEqual    (i_brEqual),
    .o_taken      (o_taken),
    .o_mispredict (o_mispredict),
    .o_redirectPc (o_redirectPc),
    .o_illegal    (o_illegal),
    .o_brCount    (o_brCount),
    .o_mispCount  (o_mispCount)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [2:0]  f3;
    logic        lt;
    logic        eq;
    logic        pr;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tk;
    logic        ms;
    logic        il;
    logic [31:0] rpc;
  } vec_t;

  typedef struct {
    logic        ms;
    logic        il;
    logic [31:0] rpc;
  } sb_t;

  vec_t tbl [10];
  sb_t  q [$];
  int   checks = 0;
  int   failures = 0;
  int   exp_br = 0;
  int   exp_msp = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_in(input vec_t v);
    i_funct3    = v.f3;
    i_brLess    = v.lt;
    i_brEqual   = v.eq;
    i_predTaken = v.pr;
    i_pc        = v.pc;
    i_target    = v.tgt;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_valid = 1'b0;
    cyc();
    i_reset = 1'b0;
    exp_br  = 0;
    exp_msp = 0;
  endtask

  task automatic drive_br(input vec_t v);
    sb_t e;
    set_in(v);
    i_valid = 1'b1;
    #1;
    chk("taken", {31'd0, o_taken}, {31'd0, v.tk});
    chk("unsign", {31'd0, o_brUnsign}, {31'd0, v.f3[1]});
    e.ms  = v.ms;
    e.il  = v.il;
    e.rpc = v.rpc;
    q.push_back(e);
    if (!v.il) exp_br++;
    if (v.ms) exp_msp++;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    if (q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      chk("misp", {31'd0, o_mispredict}, {31'd0, e.ms});
      chk("illegal", {31'd0, o_illegal}, {31'd0, e.il});
      if (e.ms) chk("rpc", o_redirectPc, e.rpc);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] f3, input logic lt,
                              input logic eq, input logic pr,
                              input logic [31:0] pc,
                              input logic [31:0] tgt,
                              input logic tk, input logic ms,
                              input logic il,
                              input logic [31:0] rpc);
    vec_t v;
    v.f3 = f3; v.lt = lt; v.eq = eq; v.pr = pr;
    v.pc = pc; v.tgt = tgt; v.tk = tk; v.ms = ms;
    v.il = il; v.rpc = rpc;
    return v;
  endfunction

  task automatic chk_stats(input string n);
`ifdef BR_RESOLVER_STATS_EN
    chk({n, "_brcnt"}, o_brCount, exp_br);
    chk({n, "_mspcnt"}, o_mispCount, exp_msp);
`else
    chk({n, "_brcnt"}, o_brCount, 32'h0);
    chk({n, "_mspcnt"}, o_mispCount, 32'h0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    tbl[0] = mk(3'b000, 0, 1, 0, 32'h40, 32'h80, 1, 1, 0, 32'h80);
    tbl[1] = mk(3'b001, 0, 1, 0, 32'h20, 32'h90, 0, 0, 0, 32'h0);
    tbl[2] = mk(3'b100, 1, 0, 1, 32'h24, 32'h94, 1, 0, 0, 32'h0);
    tbl[3] = mk(3'b101, 1, 0, 1, 32'h200, 32'h98, 0, 1, 0, 32'h204);
    tbl[4] = mk(3'b110, 1, 0, 1, 32'h28, 32'h9c, 1, 0, 0, 32'h0);
    tbl[5] = mk(3'b111, 0, 0, 0, 32'h2c, 32'h300, 1, 1, 0, 32'h300);
    tbl[6] = mk(3'b010, 1, 1, 1, 32'h30, 32'ha0, 0, 0, 1, 32'h0);
    tbl[7] = mk(3'b011, 1, 1, 0, 32'h34, 32'ha4, 0, 0, 1, 32'h0);
    tbl[8] = mk(3'b000, 0, 0, 1, 32'hFFFFFFFC, 32'h8, 0, 1, 0, 32'h0);
    tbl[9] = mk(3'b001, 0, 0, 0, 32'h38, 32'h500, 1, 1, 0, 32'h500);

    i_reset = 1'b1; i_valid = 1'b0; i_fetchPc = 32'h100;
    i_pc = '0; i_target = '0; i_funct3 = 3'b110;
    i_predTaken = 1'b0; i_brLess = 1'b0; i_brEqual = 1'b0;
    cyc();
    cyc();
    chk("rst_unsign", {31'd0, o_brUnsign}, 32'd1);
    i_reset = 1'b0;
    #1;
    chk("rst_misp", {31'd0, o_mispredict}, 32'd0);
    chk("rst_ill", {31'd0, o_illegal}, 32'd0);
    chk("rst_rpc", o_redirectPc, 32'h0);
    chk("rst_pred100", {31'd0, o_predTaken}, 32'd0);
    chk_stats("rst");
    for (int i = 0; i < 16; i++) begin
      i_fetchPc = i * 4;
      #1;
      chk($sformatf("rst_pred%0d", i), {31'd0, o_predTaken}, 32'd0);
    end
    cyc();

    for (int i = 0; i < 10; i++) begin
      drive_br(tbl[i]);
      cyc();
      chk($sformatf("pulse_end%0d", i), {30'd0, o_mispredict, o_illegal},
          32'd0);
      cyc();
      cyc();
    end
    chk_stats("tbl");

    // Flush window: two ignored pulses, third accepted.
    v = tbl[0];
    set_in(v);
    i_valid = 1'b1;
    #1;
    chk("fl_take0", {31'd0, o_taken}, 32'd1);
    cyc();
    chk("fl_misp0", {31'd0, o_mispredict}, 32'd1);
    chk("fl_rpc0", o_redirectPc, 32'h80);
    chk("fl_ign1", {31'd0, o_taken}, 32'd0);
    cyc();
    chk("fl_nomisp1", {31'd0, o_mispredict}, 32'd0);
    chk("fl_ign2", {31'd0, o_taken}, 32'd0);
    cyc();
    chk("fl_nomisp2", {31'd0, o_mispredict}, 32'd0);
    chk("fl_acc3", {31'd0, o_taken}, 32'd1);
    cyc();
    i_valid = 1'b0;
    chk("fl_misp3", {31'd0, o_mispredict}, 32'd1);
    exp_br += 2;
    exp_msp += 2;
    chk_stats("fl");
    cyc(); cyc(); cyc();

    // Reset during flush, with a simultaneous valid.
    set_in(tbl[0]);
    i_valid = 1'b1;
    cyc();
    chk("rf_misp", {31'd0, o_mispredict}, 32'd1);
    i_reset = 1'b1;
    #1;
    chk("rf_ovr_taken", {31'd0, o_taken}, 32'd0);
    cyc();
    i_reset = 1'b0;
    exp_br = 0;
    exp_msp = 0;
    chk("rf_misp_clr", {31'd0, o_mispredict}, 32'd0);
    chk("rf_rpc_clr", o_redirectPc, 32'h0);
    chk_stats("rf");
    drive_br(mk(3'b110, 1, 0, 1, 32'h80, 32'hc0, 1, 0, 0, 32'h0));
    chk_stats("rf_after");

    // BHT saturation at index of pc 0x10.
    do_reset();
    i_fetchPc = 32'h10;
    #1;
    chk("bht_init", {31'd0, o_predTaken}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive_br(mk(3'b000, 0, 1, 1, 32'h10, 32'h60, 1, 0, 0, 32'h0));
      chk($sformatf("bht_t%0d", i), {31'd0, o_predTaken}, 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("bht_pre%0d", i), {31'd0, o_predTaken},
          (i < 2) ? 32'd1 : 32'd0);
      drive_br(mk(3'b000, 0, 0, 0, 32'h10, 32'h60, 0, 0, 0, 32'h0));
      chk($sformatf("bht_n%0d", i), {31'd0, o_predTaken},
          (i < 1) ? 32'd1 : 32'd0);
    end
    drive_br(mk(3'b000, 0, 1, 0, 32'h10, 32'h60, 1, 1, 0, 32'h60));
    chk("bht_low_sat", {31'd0, o_predTaken}, 32'd0);
    i_fetchPc = 32'h14;
    #1;
    chk("bht_other", {31'd0, o_predTaken}, 32'd0);
    cyc(); cyc(); cyc();

    // Illegal funct3 leaves BHT and FSM untouched.
    do_reset();
    i_fetchPc = 32'h10;
    drive_br(mk(3'b010, 0, 0, 1, 32'h10, 32'h60, 0, 0, 1, 32'h0));
    chk("ill_bht", {31'd0, o_predTaken}, 32'd0);
    drive_br(mk(3'b000, 0, 1, 1, 32'h10, 32'h60, 1, 0, 0, 32'h0));
    chk("ill_bht_up", {31'd0, o_predTaken}, 32'd1);
    chk_stats("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
Consumer end of the branch comparator interface in the RV32I core.
- Drives the comparator's unsigned-select input from the branch funct3.
- Reads back the less/equal flags and resolves the branch outcome.
- Compares the outcome with the fetch-stage prediction. On a mismatch it issues a registered redirect and a timed flush window.
- Holds a small 2-bit saturating branch history table (BHT) that supplies the fetch-stage prediction.

Parameters:
- IDX_W, 4, BHT index width; the table has 2**IDX_W entries, indexed by pc[IDX_W+1:2].
- FLUSH_CYCLES, 2, number of cycles resolve inputs are ignored after a mispredict (minimum 1).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_fetchPc  in  32  PC being fetched; drives the BHT lookup
- o_predTaken  out  1  prediction for i_fetchPc: bit 1 of the indexed counter (combinational)
- i_valid  in  1  a branch is resolving this cycle
- i_pc  in  32  PC of the resolving branch
- i_target  in  32  branch target address
- i_funct3  in  3  branch funct3
- i_predTaken  in  1  prediction that was made for this branch
- o_brUnsign  out  1  to comparator i_brUnsign; equals i_funct3[1] (combinational)
- i_brLess  in  1  comparator less flag
- i_brEqual  in  1  comparator equal flag
- o_taken  out  1  resolved outcome (combinational; gated by acceptance)
- o_mispredict  out  1  registered, one-cycle pulse
- o_redirectPc  out  32  registered; valid while o_mispredict = 1
- o_illegal  out  1  registered, one-cycle pulse
- o_brCount  out  32  accepted branch count (optional feature)
- o_mispCount  out  32  mispredict count (optional feature)

Behaviour:
- Outcome decode by i_funct3:
  - 000 BEQ: taken = eq
  - 001 BNE: taken = !eq
  - 100 BLT: taken = less
  - 101 BGE: taken = !less
  - 110 BLTU: taken = less
  - 111 BGEU: taken = !less
  - 010/011: illegal; taken = 0
- o_brUnsign = i_funct3[1] at all times, including reset and flush.
- Acceptance: accept = i_valid && state == IDLE && !i_reset. o_taken = accept && decoded taken.
- State machine, states IDLE and FLUSH:
  - IDLE -> FLUSH when accept && legal && taken != i_predTaken. A flush counter loads FLUSH_CYCLES-1.
  - FLUSH: counter decrements each cycle; returns to IDLE on the edge where the counter is 0.
  - i_valid in FLUSH is ignored: no BHT update, no pulses.
- Mispredict (edge after accept):
  - o_mispredict = 1 for exactly one cycle.
  - o_redirectPc = taken ? i_target : i_pc + 32'd4. Addition wraps modulo 2**32.
  - o_redirectPc holds its last value otherwise.
- Illegal funct3 when accepted:
  - o_illegal pulses one cycle after.
  - No BHT update, no mispredict, no state change.
- BHT:
  - Each entry is a 2-bit counter.
  - On an accepted legal branch at the clock edge: taken increments, saturating at 11; not-taken decrements, saturating at 00.
  - Lookup and update on the same index in the same cycle: o_predTaken returns the pre-update value.
- Reset (synchronous, active-high), also mid-FLUSH:
  - state = IDLE; all BHT entries = 01 (weakly not-taken).
  - o_mispredict = 0, o_illegal = 0, o_redirectPc = 0.
  - Counters = 0.
- i_reset overrides any simultaneous i_valid.

Optional Feature:
- Macro: BR_RESOLVER_STATS_EN.
- Defined:
  - o_brCount increments on every accepted legal branch.
  - o_mispCount increments on every mispredict.
  - Both wrap from FFFFFFFF to 0 and clear on reset.
- Undefined: both ports are tied to 32'h0 and no counter flops are built.

Test Plan:
- Reset, then i_fetchPc = 0x100 -> o_predTaken = 0. Every index reads 0 after reset.
- BEQ (funct3 = 000), eq = 1, predTaken = 0, pc = 0x40, target = 0x80:
  - Next cycle: o_mispredict = 1, o_redirectPc = 0x80.
  - The following 2 i_valid pulses are ignored; the 3rd is accepted.
- BLTU (funct3 = 110): o_brUnsign = 1; less = 1, predTaken = 1 -> o_taken = 1, no mispredict. BGE: o_brUnsign = 0.
- Three taken branches at pc = 0x10 -> o_predTaken for i_fetchPc = 0x10 goes 0 -> 1 after the 1st update, then saturates at 11. Four not-taken branches -> 0.
- funct3 = 010 accepted -> o_illegal pulses; BHT unchanged; no mispredict.
- Mispredict followed by i_reset asserted during FLUSH -> the next-cycle i_valid is accepted; with BR_RESOLVER_STATS_EN, o_mispCount = 0.
